// File: rtl/iob_regfile_mp.sv
// Multi-read-port register file with byte-strobed writes, selectable read latency,
// optional write-to-read forwarding and a sequential clear engine.
module iob_regfile_mp #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32,
   parameter int N_RD   = 2,
   parameter int RD_LAT = 1,
   parameter int BYPASS = 1
) (
   input  logic                     ap_clk,
   input  logic                     rst,
   input  logic                     clr,
   output logic                     busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic [DATA_W-1:0]        w_data,
   input  logic [DATA_W/8-1:0]      w_strb,
   input  logic [N_RD-1:0]          rd_en,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_RD-1:0]          rd_valid
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;
   logic [DATA_W-1:0] wr_merged;

   assign busy  = (state == ST_CLEAR);
   // clr takes priority over a write issued in the same idle cycle
   assign wr_ok = we & ~busy & ~clr;

   always_comb begin
      wr_merged = mem[w_addr];
      for (int unsigned b = 0; b < NB; b++) begin
         if (w_strb[b]) wr_merged[8*b +: 8] = w_data[8*b +: 8];
      end
   end

   always_ff @(posedge ap_clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (clr) state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               if (cnt == '1) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge ap_clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (busy) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         mem[w_addr] <= wr_merged;
      end
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[p*ADDR_W +: ADDR_W];

      if (RD_LAT == 0) begin : g_comb
         assign rd_data[p*DATA_W +: DATA_W] = mem[a];
         assign rd_valid[p]                 = rd_en[p] & ~busy;
      end else begin : g_reg
         logic [DATA_W-1:0] fwd;
         logic [DATA_W-1:0] q;
         logic              v;

         // Forwarding returns the post-write entry: strobed bytes new, the rest old
         always_comb begin
            fwd = mem[a];
            if (BYPASS != 0 && wr_ok && w_addr == a) fwd = wr_merged;
         end

         always_ff @(posedge ap_clk or posedge rst) begin
            if (rst) begin
               q <= '0;
               v <= 1'b0;
            end else begin
               v <= rd_en[p] & ~busy;
               if (rd_en[p] & ~busy) q <= fwd;
            end
         end

         assign rd_data[p*DATA_W +: DATA_W] = q;
         assign rd_valid[p]                 = v;
      end
   end

endmodule

// File: tb/tb_iob_regfile_mp.sv
// Self-checking bench for iob_regfile_mp (4 x 32, 2 read ports, RD_LAT=1, BYPASS=1).
module tb_iob_regfile_mp;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int NR = 2;

   logic             ap_clk = 1'b0;
   logic             rst;
   logic             clr;
   logic             busy;
   logic             we;
   logic [AW-1:0]    w_addr;
   logic [DW-1:0]    w_data;
   logic [DW/8-1:0]  w_strb;
   logic [NR-1:0]    rd_en;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_valid;

   int n_run  = 0;
   int n_fail = 0;
   int step_no = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   typedef struct {
      logic        we;
      logic [1:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [1:0]  re;
      logic [1:0]  ra0;
      logic [1:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t tbl[14];

   iob_regfile_mp #(
      .ADDR_W(AW), .DATA_W(DW), .N_RD(NR), .RD_LAT(1), .BYPASS(1)
   ) dut (
      .ap_clk(ap_clk), .rst(rst), .clr(clr), .busy(busy),
      .we(we), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h expected %h", name, step_no, act, exp);
      end
   endtask

   // Advance one clock and retire whatever the scoreboard expects from that edge
   task automatic step();
      logic [31:0] e;
      @(posedge ap_clk);
      #1;
      step_no++;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("p0_valid", 32'(rd_valid[0]), 32'd1);
         chk("p0_data", rd_data[31:0], e);
      end else begin
         chk("p0_valid_idle", 32'(rd_valid[0]), 32'd0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("p1_valid", 32'(rd_valid[1]), 32'd1);
         chk("p1_data", rd_data[63:32], e);
      end else begin
         chk("p1_valid_idle", 32'(rd_valid[1]), 32'd0);
      end
   endtask

   task automatic apply(input logic i_we, input logic [1:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [1:0] re, input logic [1:0] ra0,
                        input logic [1:0] ra1, input logic i_clr, input logic [1:0] xv,
                        input logic [31:0] e0, input logic [31:0] e1);
      we      = i_we;
      w_addr  = wa;
      w_data  = wd;
      w_strb  = ws;
      rd_en   = re;
      rd_addr = {ra1, ra0};
      clr     = i_clr;
      if (xv[0]) q0.push_back(e0);
      if (xv[1]) q1.push_back(e1);
      step();
   endtask

   task automatic idle_inputs();
      we = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
      rd_en = '0; rd_addr = '0; clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      tbl[0]  = '{1'b1, 2'd1, 32'hDEADBEEF, 4'hF, 2'b00, 2'd0, 2'd0, 32'h0,        32'h0};
      tbl[1]  = '{1'b1, 2'd1, 32'h11223344, 4'h5, 2'b11, 2'd1, 2'd0, 32'hDE22BE44, 32'h0};
      tbl[2]  = '{1'b0, 2'd0, 32'h0,        4'h0, 2'b11, 2'd1, 2'd1, 32'hDE22BE44, 32'hDE22BE44};
      tbl[3]  = '{1'b1, 2'd0, 32'hFFFFFFFF, 4'h0, 2'b11, 2'd0, 2'd1, 32'h0,        32'hDE22BE44};
      tbl[4]  = '{1'b1, 2'd0, 32'h000000A0, 4'hF, 2'b00, 2'd0, 2'd0, 32'h0,        32'h0};
      tbl[5]  = '{1'b1, 2'd1, 32'h000000A1, 4'hF, 2'b10, 2'd0, 2'd0, 32'h0,        32'h000000A0};
      tbl[6]  = '{1'b1, 2'd2, 32'h000000A2, 4'hF, 2'b00, 2'd0, 2'd0, 32'h0,        32'h0};
      tbl[7]  = '{1'b1, 2'd3, 32'h000000A3, 4'hF, 2'b01, 2'd1, 2'd0, 32'h000000A1, 32'h0};
      tbl[8]  = '{1'b0, 2'd0, 32'h0,        4'h0, 2'b11, 2'd2, 2'd3, 32'h000000A2, 32'h000000A3};
      tbl[9]  = '{1'b1, 2'd0, 32'h12345678, 4'hF, 2'b00, 2'd0, 2'd0, 32'h0,        32'h0};
      tbl[10] = '{1'b1, 2'd0, 32'hFFFFFFFF, 4'h3, 2'b11, 2'd0, 2'd0, 32'h1234FFFF, 32'h1234FFFF};
      tbl[11] = '{1'b0, 2'd0, 32'h0,        4'h0, 2'b11, 2'd0, 2'd2, 32'h1234FFFF, 32'h000000A2};
      tbl[12] = '{1'b1, 2'd3, 32'h55667788, 4'h2, 2'b11, 2'd2, 2'd3, 32'h000000A2, 32'h000077A3};
      tbl[13] = '{1'b0, 2'd0, 32'h0,        4'h0, 2'b01, 2'd3, 2'd0, 32'h000077A3, 32'h0};

      // Power-on reset
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge ap_clk);
      #1;
      chk("reset_valid", 32'(rd_valid), 32'd0);
      chk("reset_data0", rd_data[31:0], 32'h0);
      chk("reset_data1", rd_data[63:32], 32'h0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ws, tbl[i].re, tbl[i].ra0,
               tbl[i].ra1, 1'b0, tbl[i].re, tbl[i].e0, tbl[i].e1);
      end

      // Clear with a concurrent write (dropped) and a read (still served)
      apply(1'b1, 2'd1, 32'hBBBBBBBB, 4'hF, 2'b01, 2'd1, 2'd0, 1'b1, 2'b01, 32'h000000A1, 32'h0);
      chk("busy_rise", 32'(busy), 32'd1);
      cyc = 0;
      while (busy && cyc < 10) begin
         apply(1'b1, 2'd2, 32'h99999999, 4'hF, 2'b11, 2'd2, 2'd3, (cyc == 0), 2'b00, 32'h0, 32'h0);
         cyc++;
      end
      chk("clear_len", 32'(cyc), 32'd4);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd0, 2'd1, 1'b0, 2'b11, 32'h0, 32'h0);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd2, 2'd3, 1'b0, 2'b11, 32'h0, 32'h0);
      apply(1'b1, 2'd2, 32'hCAFEF00D, 4'hF, 2'b00, 2'd0, 2'd0, 1'b0, 2'b00, 32'h0, 32'h0);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd2, 2'd2, 1'b0, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D);

      // Asynchronous reset with dirty entries and live read data
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(rd_valid), 32'd0);
      chk("async_rst_data0", rd_data[31:0], 32'h0);
      chk("async_rst_data1", rd_data[63:32], 32'h0);
      q0.delete();
      q1.delete();
      @(posedge ap_clk);
      #1;
      rst = 1'b0;
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd0, 2'd1, 1'b0, 2'b11, 32'h0, 32'h0);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd2, 2'd3, 1'b0, 2'b11, 32'h0, 32'h0);

      // Reset in the middle of a clear
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 2'(i), 32'h5A5A5A00 + 32'(i), 4'hF, 2'b00, 2'd0, 2'd0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b00, 2'd0, 2'd0, 1'b1, 2'b00, 32'h0, 32'h0);
      chk("midclr_busy1", 32'(busy), 32'd1);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("midclr_busy2", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midclr_rst_busy", 32'(busy), 32'd0);
      @(posedge ap_clk);
      #1;
      rst = 1'b0;
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd0, 2'd1, 1'b0, 2'b11, 32'h0, 32'h0);
      chk("midclr_idle", 32'(busy), 32'd0);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b11, 2'd2, 2'd3, 1'b0, 2'b11, 32'h0, 32'h0);
      apply(1'b1, 2'd3, 32'h0BADCAFE, 4'hF, 2'b01, 2'd3, 2'd0, 1'b0, 2'b01, 32'h0BADCAFE, 32'h0);
      apply(1'b0, 2'd0, 32'h0, 4'h0, 2'b10, 2'd0, 2'd3, 1'b0, 2'b10, 32'h0, 32'h0BADCAFE);
      chk("midclr_still_idle", 32'(busy), 32'd0);

      idle_inputs();
      step();
      chk("sb_drain", 32'(q0.size() + q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
